// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    // Every digit dark (the select lines are active-low).
    localparam logic [MAX_DIGITS-1:0] BLANK_ALL = '1;

    // Leading-zero blank mask.
    // Bit i is set when nibble i and every nibble above it, up to 'digits', are zero.
    // Digit 0 is never blanked, so a value of zero still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
        input logic [4*MAX_DIGITS-1:0] v,
        input int                      digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = BLANK_ALL;
        seen = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits) begin
                if (v[4*i +: 4] != 4'h0) begin
                    seen = 1'b1;
                end
                mask[i] = ~seen & (i != 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1. It flags the last cycle of a slot
// and the dead-time window at the start of a slot.
module seg_tick_gen #(
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [$clog2(CLK_DIV)-1:0] cnt,
    output logic                       tick,
    output logic                       in_dead
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick    = (cnt_q == CW'(CLK_DIV - 1));
    assign in_dead = (cnt_q < CW'(DEAD));
    assign cnt     = cnt_q;

    // Next count: wrap to zero on the last cycle of the slot.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner. It drives one nibble at a time to the
// downstream hex decoder and the matching active-low digit select, with a
// dead-time guard and leading-zero blanking. New values take effect only at
// frame boundaries.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    output logic [3:0]          bin_data,
    output logic [DIGITS-1:0]   dig_sel,
    output logic                frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam int PW = 4 * MAX_DIGITS;

    localparam logic [CW-1:0] DEAD_LAST = (DEAD == 0) ? '0 : CW'(DEAD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic          in_dead;

    logic [IW-1:0] idx_q,     idx_d;
    logic [VW-1:0] pending_q, pending_d;
    logic          pend_v_q,  pend_v_d;
    logic [VW-1:0] shadow_q,  shadow_d;

    logic [3:0]        bin_data_q,   bin_data_d;
    logic [DIGITS-1:0] dig_sel_q,    dig_sel_d;
    logic              frame_done_q, frame_done_d;

    logic              boundary;
    logic              dead_d;
    logic [DIGITS-1:0] blank_d;

    seg_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .DEAD    (DEAD)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .tick    (tick),
        .in_dead (in_dead)
    );

    // Next state: digit index, the staged value and the frame-boundary swap into the shadow register.
    always_comb begin
        boundary = tick && (idx_q == IDX_LAST);

        idx_d = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + IW'(1);
        end

        pending_d = load ? value : pending_q;

        pend_v_d = pend_v_q;
        if (boundary) begin
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_v_d = 1'b1;
        end

        // A load on the boundary cycle itself bypasses the staging register.
        shadow_d = shadow_q;
        if (boundary) begin
            if (load) begin
                shadow_d = value;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
            end
        end

        // Dead window for the next count. Once out of it we stay out until the wrap.
        dead_d = tick ? (DEAD != 0) : (in_dead && (cnt != DEAD_LAST));
    end

    // Output decode from next state, so the registered outputs line up with the counter.
    always_comb begin
        blank_d      = DIGITS'(lz_blank_mask(PW'(shadow_d), DIGITS));
        bin_data_d   = 4'h0;
        dig_sel_d    = DIGITS'(BLANK_ALL);
        frame_done_d = boundary;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                bin_data_d = shadow_d[4*i +: 4];
                if (!dead_d && !blank_d[i]) begin
                    dig_sel_d[i] = 1'b0;
                end
            end
        end
    end

    // State and output registers. Reset drops any staged value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            shadow_q     <= '0;
            bin_data_q   <= 4'h0;
            dig_sel_q    <= DIGITS'(BLANK_ALL);
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            shadow_q     <= shadow_d;
            bin_data_q   <= bin_data_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bin_data   = bin_data_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan. It uses DIGITS=4, CLK_DIV=8 and DEAD=2.
module tb_seg_scan;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  bin_data;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: each entry is {frame_done, dig_sel, bin_data} for one cycle.
    logic [8:0] exp_q[$];
    int         t_q[$];

    // Reference model state. t counts cycles since reset release.
    int          t;
    logic [15:0] m_shadow;
    logic [15:0] m_pend;
    bit          m_pend_v;

    seg_scan #(
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV),
        .DEAD    (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .bin_data   (bin_data),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for cycle tt when the displayed value is sh.
    function automatic logic [8:0] expect_out(input int tt, input logic [15:0] sh);
        int         c;
        int         s;
        logic [3:0] nib;
        logic [3:0] sel;
        logic       fd;
        logic       blank;
        c     = tt % CLK_DIV;
        s     = (tt / CLK_DIV) % DIGITS;
        nib   = sh[4*s +: 4];
        blank = (s != 0) && ((sh >> (4*s)) == 16'h0);
        sel   = 4'hF;
        if (c >= DEAD && !blank) sel[s] = 1'b0;
        fd    = (tt > 0) && (tt % FRAME == 0);
        return {fd, sel, nib};
    endfunction

    // Monitor: pops one expectation per cycle and compares it on the falling edge.
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        int         tt;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            tt = t_q.pop_front();
            checks++;
            if ({frame_done, dig_sel, bin_data} !== e) begin
                failures++;
                $display("FAIL scan t=%0d got fd=%0b sel=%h bin=%h expected fd=%0b sel=%h bin=%h",
                         tt, frame_done, dig_sel, bin_data, e[8], e[7:4], e[3:0]);
            end
        end
    end

    // Direct comparison for the asynchronous reset checks.
    task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // One cycle. We enter just after a rising edge and leave just after the next one.
    task automatic step(input bit ld, input logic [15:0] v);
        load  = ld;
        value = v;
        exp_q.push_back(expect_out(t, m_shadow));
        t_q.push_back(t);
        @(posedge clk);
        if (ld) begin
            m_pend   = v;
            m_pend_v = 1'b1;
        end
        if (t % FRAME == FRAME - 1) begin
            if (m_pend_v) m_shadow = m_pend;
            m_pend_v = 1'b0;
        end
        t++;
        #1;
        load  = 1'b0;
        value = 16'h0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic idle_to(input int phase);
        while (t % FRAME != phase) step(1'b0, 16'h0);
    endtask

    // Asynchronous reset between clock edges, with immediate output checks.
    task automatic pulse_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_now("async_rst_sel", {4'h0, dig_sel}, 8'h0F);
        check_now("async_rst_bin", {4'h0, bin_data}, 8'h00);
        check_now("async_rst_fd", {7'h0, frame_done}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        t        = 0;
        m_shadow = 16'h0;
        m_pend   = 16'h0;
        m_pend_v = 1'b0;
    endtask

    // Stimulus.
    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        t        = 0;
        m_shadow = 16'h0;
        m_pend   = 16'h0;
        m_pend_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now("rst_sel", {4'h0, dig_sel}, 8'h0F);
        check_now("rst_bin", {4'h0, bin_data}, 8'h00);
        check_now("rst_fd", {7'h0, frame_done}, 8'h00);
        rst_n = 1'b1;

        // Blank display after reset: only digit 0 is lit, showing 0.
        run(40);

        // Basic value: F, A, 2, 1 over slots 0..3 from the next frame.
        idle_to(5);
        step(1'b1, 16'h12AF);
        run(96);

        // Reset mid-slot while digit 1 is lit.
        idle_to(12);
        pulse_reset();
        run(40);

        // Leading-zero blanking.
        idle_to(3);
        step(1'b1, 16'h00A0);
        run(64);
        idle_to(3);
        step(1'b1, 16'h0000);
        run(64);

        // Last load before the boundary wins.
        idle_to(10);
        step(1'b1, 16'h1111);
        idle_to(26);
        step(1'b1, 16'h2222);
        run(64);

        // Load exactly on the frame-boundary tick.
        idle_to(FRAME - 1);
        step(1'b1, 16'hBEEF);
        run(64);

        // Reset discards a pending load.
        idle_to(5);
        step(1'b1, 16'h5A5A);
        run(3);
        pulse_reset();
        run(40);

        // Random loads at random phases, sometimes several per frame.
        for (int k = 0; k < 25; k++) begin
            run($urandom_range(0, 45));
            if ($urandom_range(0, 3) == 0) idle_to(FRAME - 1);
            step(1'b1, 16'($urandom));
        end
        run(70);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
